// File: rtl/sequence_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sequence_ram_arbiter
//
// Owns the single-port sequence RAM (DEPTH x 20 bits) and shares it between a
// write requester (sequence storage) and a read requester (playback/compare).
// Only one transaction is in flight at a time, so RAM_W / RAM_addr have a
// single driver and no read can ever observe a half-finished write.
//
// Optional feature macro: SEQ_ARB_WR_PRIORITY_EN
//   undefined : round-robin between the two requesters (default)
//   defined   : writes always win contention; reads may starve
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   wr_req    write request, held with wr_addr/wr_data until wr_ack
//   wr_addr   write address
//   wr_data   write data
//   wr_ack    one-cycle pulse: write performed (or dropped when out of range)
//   rd_req    read request, held with rd_addr until rd_valid
//   rd_addr   read address
//   rd_data   read result, valid with rd_valid and held afterwards
//   rd_valid  one-cycle pulse: rd_data valid
//   addr_err  one-cycle pulse with wr_ack/rd_valid when address >= DEPTH
//   RAM_W     RAM write enable
//   RAM_addr  RAM address
//   RAM_din   RAM write data
//   RAM_dout  RAM read data, valid RD_LAT cycles after RAM_addr
//   busy      high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module sequence_ram_arbiter #(
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [4:0]  wr_addr,
  input  logic [19:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [4:0]  rd_addr,
  output logic [19:0] rd_data,
  output logic        rd_valid,
  output logic        addr_err,
  output logic        RAM_W,
  output logic [4:0]  RAM_addr,
  output logic [19:0] RAM_din,
  input  logic [19:0] RAM_dout,
  output logic        busy
);

  localparam logic [5:0] DEPTH_L  = 6'(DEPTH);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        oor_q;
  logic        wr_ack_q;
  logic        rd_valid_q;
  logic        addr_err_q;
  logic        ram_w_q;
  logic [4:0]  ram_addr_q;
  logic [19:0] ram_din_q;
  logic [19:0] rd_data_q;
  logic        busy_q;
`ifndef SEQ_ARB_WR_PRIORITY_EN
  // 1 = the most recent grant went to the read side
  logic        last_rd_q;
`endif

  logic wr_elig, rd_elig, grant_wr, grant_rd, wr_oor, rd_oor;

  always_comb begin
    // A requester still showing its completion pulse is holding a stale
    // request; masking it here prevents a second service of the same request.
    wr_elig  = wr_req && !wr_ack_q;
    rd_elig  = rd_req && !rd_valid_q;
`ifdef SEQ_ARB_WR_PRIORITY_EN
    grant_wr = wr_elig;
`else
    grant_wr = wr_elig && (!rd_elig || last_rd_q);
`endif
    grant_rd = rd_elig && !grant_wr;
    wr_oor   = {1'b0, wr_addr} >= DEPTH_L;
    rd_oor   = {1'b0, rd_addr} >= DEPTH_L;
  end

  // Every output is a register; the pulses default low and are set on the
  // same edge that enters the state in which they must be visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      oor_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      ram_w_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
`ifndef SEQ_ARB_WR_PRIORITY_EN
      last_rd_q  <= 1'b1;
`endif
    end else begin
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q    <= WRITE;
            busy_q     <= 1'b1;
            ram_addr_q <= wr_addr;
            ram_din_q  <= wr_data;
            ram_w_q    <= !wr_oor;
            wr_ack_q   <= 1'b1;
            addr_err_q <= wr_oor;
`ifndef SEQ_ARB_WR_PRIORITY_EN
            last_rd_q  <= 1'b0;
`endif
          end else if (grant_rd) begin
            state_q    <= READ;
            busy_q     <= 1'b1;
            ram_addr_q <= rd_addr;
            oor_q      <= rd_oor;
            cnt_q      <= '0;
`ifndef SEQ_ARB_WR_PRIORITY_EN
            last_rd_q  <= 1'b1;
`endif
          end
        end
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ram_w_q <= 1'b0;
        end
        READ: begin
          // RAM_addr has been stable since entry; wait out the RAM latency.
          if (cnt_q == LAT_LAST) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        CAPTURE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          cnt_q      <= '0;
          rd_data_q  <= oor_q ? '0 : RAM_dout;
          rd_valid_q <= 1'b1;
          addr_err_q <= oor_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ram_w_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ack   = wr_ack_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign RAM_W    = ram_w_q;
  assign RAM_addr = ram_addr_q;
  assign RAM_din  = ram_din_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sequence_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for sequence_ram_arbiter. A behavioural RAM with RD_LAT cycles of read
// latency sits on the RAM pins. Stimulus pushes each request into a per-side
// queue; a negedge monitor pops on wr_ack/rd_valid and checks the result
// against a plain array holding what memory should contain.
// -----------------------------------------------------------------------------
module tb_sequence_ram_arbiter;

  localparam int DEPTH  = 24;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [19:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [4:0]  wr_addr;
  logic [19:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic        addr_err;
  logic        RAM_W;
  logic [4:0]  RAM_addr;
  logic [19:0] RAM_din;
  logic [19:0] RAM_dout;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic ram_clr;

  wr_t         wr_q[$];
  logic [4:0]  rd_q[$];
  logic [19:0] model_mem [32];
  logic [19:0] ram [32];
  logic [19:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  sequence_ram_arbiter #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err), .RAM_W(RAM_W), .RAM_addr(RAM_addr), .RAM_din(RAM_din),
    .RAM_dout(RAM_dout), .busy(busy)
  );

  // Physical RAM has DEPTH rows; addresses beyond it return junk.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else if (RAM_W) begin
      ram[RAM_addr] <= RAM_din;
    end
    rd_pipe[0] <= (RAM_addr >= 5'(DEPTH)) ? 20'hFACED : ram[RAM_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign RAM_dout = rd_pipe[RD_LAT-1];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [19:0] exp_rd(input logic [4:0] a);
    return (a >= 5'(DEPTH)) ? 20'h0 : model_mem[a];
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
    end
    if (rst) begin
      check("ack_valid_overlap", 32'(wr_ack & rd_valid), 32'd0);
      if (wr_ack) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wr_ack: got wr_ack=1 expected no pending write at %0t", $time);
        end else begin
          wr_t e;
          logic oor;
          e   = wr_q.pop_front();
          oor = (e.addr >= 5'(DEPTH));
          check("wr_addr_err", 32'(addr_err), 32'(oor));
          check("wr_ram_w", 32'(RAM_W), 32'(!oor));
          check("wr_ram_addr", 32'(RAM_addr), 32'(e.addr));
          if (!oor) begin
            check("wr_ram_din", 32'(RAM_din), 32'(e.data));
            model_mem[e.addr] = e.data;
          end
        end
      end else begin
        check("ram_w_without_ack", 32'(RAM_W), 32'd0);
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no pending read at %0t", $time);
        end else begin
          logic [4:0] a;
          a = rd_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(exp_rd(a)));
          check("rd_addr_err", 32'(addr_err), 32'(a >= 5'(DEPTH)));
        end
      end
      if (!wr_ack && !rd_valid) check("addr_err_stray", 32'(addr_err), 32'd0);
    end
  end

  task automatic directed_write(input logic [4:0] a, input logic [19:0] d);
    @(posedge clk); #1;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    wr_q.push_back('{addr: a, data: d});
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      check("dw_ack", 32'(wr_ack), 32'(c == 1));
      check("dw_busy", 32'(busy), 32'(c == 1));
      check("dw_ram_w", 32'(RAM_W), 32'((c == 1) && (a < 5'(DEPTH))));
      if (c == 1) begin
        check("dw_ram_addr", 32'(RAM_addr), 32'(a));
        check("dw_ram_din", 32'(RAM_din), 32'(d));
        check("dw_addr_err", 32'(addr_err), 32'(a >= 5'(DEPTH)));
        @(posedge clk); #1;
        wr_req = 1'b0;
      end
    end
  endtask

  // rd_req stays high through the rd_valid cycle, as a registered requester
  // would, so the read side is also checked for double service.
  task automatic directed_read(input logic [4:0] a);
    @(posedge clk); #1;
    rd_addr = a; rd_req = 1'b1;
    rd_q.push_back(a);
    for (int c = 0; c <= 3 + RD_LAT; c++) begin
      @(negedge clk);
      check("dr_valid", 32'(rd_valid), 32'(c == 2 + RD_LAT));
      check("dr_busy", 32'(busy), 32'(c >= 1 && c <= 1 + RD_LAT));
      if (c >= 1 && c <= 1 + RD_LAT) check("dr_ram_addr", 32'(RAM_addr), 32'(a));
      if (c == 2 + RD_LAT) begin
        check("dr_data", 32'(rd_data), 32'(exp_rd(a)));
        check("dr_addr_err", 32'(addr_err), 32'(a >= 5'(DEPTH)));
        @(posedge clk); #1;
        rd_req = 1'b0;
      end
    end
  endtask

  task automatic wr_agent(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      logic seen;
      logic [4:0] a;
      logic [19:0] d;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      a = 5'($urandom_range(0, 31));
      d = 20'($urandom);
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      wr_q.push_back('{addr: a, data: d});
      seen = 1'b0; g = 0;
      while (!seen && g < 60) begin
        @(negedge clk); g++;
        seen = wr_ack;
      end
      check("wr_agent_ack_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      wr_req = 1'b0;
    end
  endtask

  task automatic rd_agent(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      logic seen;
      logic [4:0] a;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      a = 5'($urandom_range(0, 31));
      rd_addr = a; rd_req = 1'b1;
      rd_q.push_back(a);
      seen = 1'b0; g = 0;
      while (!seen && g < 60) begin
        @(negedge clk); g++;
        seen = rd_valid;
      end
      check("rd_agent_valid_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      rd_req = 1'b0;
    end
  endtask

  // Both requesters held continuously; each re-requests right after service.
  task automatic contention(input int n);
    bit order[$];
    int guard;
    logic gw, gr;
    @(posedge clk); #1;
    wr_addr = 5'($urandom_range(0, DEPTH - 1)); wr_data = 20'($urandom);
    wr_q.push_back('{addr: wr_addr, data: wr_data});
    rd_addr = 5'($urandom_range(0, DEPTH - 1));
    rd_q.push_back(rd_addr);
    wr_req = 1'b1; rd_req = 1'b1;
    guard = 0;
    while (order.size() < n && guard < 200) begin
      @(negedge clk); guard++;
      gw = wr_ack; gr = rd_valid;
      if (gw) order.push_back(1'b1);
      if (gr) order.push_back(1'b0);
      if (gw || gr) begin
        @(posedge clk); #1;
        if (order.size() < n) begin
          if (gw) begin
            wr_addr = 5'($urandom_range(0, DEPTH - 1)); wr_data = 20'($urandom);
            wr_q.push_back('{addr: wr_addr, data: wr_data});
          end
          if (gr) begin
            rd_addr = 5'($urandom_range(0, DEPTH - 1));
            rd_q.push_back(rd_addr);
          end
        end else begin
          if (gw) wr_req = 1'b0;
          if (gr) rd_req = 1'b0;
        end
      end
    end
    check("contention_count", 32'(order.size()), 32'(n));
    for (int i = 0; i < order.size(); i++) begin
`ifdef SEQ_ARB_WR_PRIORITY_EN
      check("grant_order", 32'(order[i]), 32'd1);
`else
      check("grant_order", 32'(order[i]), 32'(i % 2 == 0));
`endif
    end
    // Let whichever side is still requesting finish.
    guard = 0;
    while ((wr_req || rd_req) && guard < 100) begin
      @(negedge clk); guard++;
      gw = wr_ack; gr = rd_valid;
      if (gw || gr) begin
        @(posedge clk); #1;
        if (gw) wr_req = 1'b0;
        if (gr) rd_req = 1'b0;
      end
    end
    check("contention_drain", 32'(wr_req | rd_req), 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ram_clr = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({wr_ack, rd_valid, addr_err, RAM_W, busy, RAM_addr}), 32'd0);
    check("rst_data", 32'(rd_data | RAM_din), 32'd0);
    rst = 1'b1; ram_clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ram_w", 32'(RAM_W), 32'd0);
      check("idle_ram_addr", 32'(RAM_addr), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_pulses", 32'({wr_ack, rd_valid}), 32'd0);
    end

    directed_write(5'd5, 20'hABCDE);
    directed_read(5'd5);
    directed_write(5'd0, 20'h12345);
    directed_read(5'd0);

    contention(8);

    directed_write(5'd31, 20'h55555);
    directed_read(5'd30);
    directed_write(5'(DEPTH - 1), 20'h0F0F0);
    directed_read(5'(DEPTH - 1));

    fork
      wr_agent(40);
      rd_agent(40);
    join

    // Asynchronous reset in the middle of a read.
    @(posedge clk); #1;
    rd_addr = 5'd7; rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    check("mid_addr_pre", 32'(RAM_addr), 32'd7);
    #1;
    rst = 1'b0; rd_req = 1'b0;
    #1;
    check("mid_busy_async", 32'(busy), 32'd0);
    check("mid_addr_async", 32'(RAM_addr), 32'd0);
    check("mid_ram_w_async", 32'(RAM_W), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_no_valid_rst", 32'(rd_valid), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < RD_LAT + 4; i++) begin
      @(negedge clk);
      check("mid_no_valid_after", 32'(rd_valid), 32'd0);
    end
    directed_read(5'd7);
    directed_write(5'd7, 20'hC0FFE);
    directed_read(5'd7);

    repeat (5) @(negedge clk);
    check("wr_q_left", 32'(wr_q.size()), 32'd0);
    check("rd_q_left", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
